instr_prefetch: RTL and testbench

//  Instruction fetch front end sitting directly upstream of the single-cycle Cpu instruction port.

---
 rtl/instr_prefetch_pkg.sv | 16 +
 rtl/instr_prefetch_if.sv | 50 +++++
 rtl/fetch_fifo.sv | 62 ++++++
 rtl/instr_prefetch.sv | 108 ++++++++++
 tb/tb_instr_prefetch.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/instr_prefetch_pkg.sv
// Shared constants for the instruction prefetch front end.
// Default widths, reset fetch address, word stride and a counter-width helper.
package instr_prefetch_pkg;

  localparam int unsigned ADDR_W_DEF   = 32;
  localparam int unsigned DATA_W_DEF   = 32;
  localparam int unsigned DEPTH_DEF    = 4;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam int unsigned WORD_STRIDE  = 4;

  // Counters that must represent 0..depth inclusive.
  function automatic int unsigned cnt_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/instr_prefetch_if.sv
// Fetch front-end bundle: memory request/response channel plus core-side instruction port.
// master = prefetcher, slave = memory + core environment.
interface instr_prefetch_if
  import instr_prefetch_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
);

  logic              mem_req_valid;
  logic [ADDR_W-1:0] mem_req_addr;
  logic              mem_req_ready;
  logic              mem_resp_valid;
  logic [DATA_W-1:0] mem_resp_data;
  logic              instr_valid;
  logic [DATA_W-1:0] instr;
  logic [ADDR_W-1:0] instr_addr;
  logic              instr_ready;
  logic              redirect;
  logic [ADDR_W-1:0] redirect_addr;

  modport master (
    output mem_req_valid,
    output mem_req_addr,
    input  mem_req_ready,
    input  mem_resp_valid,
    input  mem_resp_data,
    output instr_valid,
    output instr,
    output instr_addr,
    input  instr_ready,
    input  redirect,
    input  redirect_addr
  );

  modport slave (
    input  mem_req_valid,
    input  mem_req_addr,
    output mem_req_ready,
    output mem_resp_valid,
    output mem_resp_data,
    input  instr_valid,
    input  instr,
    input  instr_addr,
    output instr_ready,
    output redirect,
    output redirect_addr
  );

endinterface

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with synchronous clear carrying {addr, data} fetch entries.
// Head entry is read straight from the storage flops; push+pop at full is allowed.
module fetch_fifo
  import instr_prefetch_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEF,
  parameter int unsigned WIDTH = ADDR_W_DEF + DATA_W_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clear,
  input  logic                      push,
  input  logic                      pop,
  input  logic [WIDTH-1:0]          din,
  output logic [WIDTH-1:0]          dout,
  output logic                      full,
  output logic                      empty,
  output logic [cnt_w(DEPTH)-1:0]   count
);

  localparam int unsigned CW = cnt_w(DEPTH);
  localparam int unsigned PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // A pop frees the slot the simultaneous push needs, so full is not a blocker then.
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      mem    <= '{default: '0};
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && !clear && full && !pop));

endmodule

// File: rtl/instr_prefetch.sv
// Sequential instruction prefetcher: credit-limited word fetches, in-order response buffering,
// and redirect handling that discards buffered and in-flight instructions.
module instr_prefetch
  import instr_prefetch_pkg::*;
#(
  parameter int unsigned       DEPTH    = DEPTH_DEF,
  parameter int unsigned       ADDR_W   = ADDR_W_DEF,
  parameter int unsigned       DATA_W   = DATA_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF)
) (
  input  logic             clk,
  input  logic             rst,
  instr_prefetch_if.master bus
);

  localparam int unsigned       CW     = cnt_w(DEPTH);
  localparam int unsigned       EW     = ADDR_W + DATA_W;
  localparam logic [ADDR_W-1:0] STRIDE = ADDR_W'(WORD_STRIDE);

  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] resp_pc;
  logic [ADDR_W-1:0] redirect_pc_c;
  logic [CW-1:0]     outstanding;
  logic [CW-1:0]     outstanding_next;
  logic [CW-1:0]     drop;
  logic [CW-1:0]     fifo_count;
  logic [CW:0]       in_use_c;
  logic              req_valid_c;
  logic              accept_c;
  logic              keep_resp_c;
  logic              pop_c;
  logic              fifo_full;
  logic              fifo_empty;
  logic [EW-1:0]     head;

  // Credit: buffered entries plus in-flight requests never exceed the FIFO depth.
  assign in_use_c         = {1'b0, fifo_count} + {1'b0, outstanding};
  assign req_valid_c      = !rst && !bus.redirect && (in_use_c < (CW+1)'(DEPTH));
  assign accept_c         = req_valid_c && bus.mem_req_ready;
  assign outstanding_next = outstanding + CW'(accept_c) - CW'(bus.mem_resp_valid);
  assign keep_resp_c      = bus.mem_resp_valid && (drop == '0) && !bus.redirect;
  assign pop_c            = !fifo_empty && bus.instr_ready;
  assign redirect_pc_c    = bus.redirect_addr & ~ADDR_W'(3);

  assign bus.mem_req_valid = req_valid_c;
  assign bus.mem_req_addr  = fetch_pc;
  assign bus.instr_valid   = !fifo_empty;
  assign bus.instr_addr    = head[EW-1:DATA_W];
  assign bus.instr         = head[DATA_W-1:0];

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clear (bus.redirect),
    .push  (keep_resp_c),
    .pop   (pop_c),
    .din   ({resp_pc, bus.mem_resp_data}),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Fetch/response address tracking and the in-flight / to-be-discarded counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      drop        <= '0;
    end else begin
      outstanding <= outstanding_next;
      if (bus.redirect) begin
        // Everything still in flight after this edge belongs to the old stream.
        fetch_pc <= redirect_pc_c;
        resp_pc  <= redirect_pc_c;
        drop     <= outstanding_next;
      end else begin
        if (accept_c) begin
          fetch_pc <= fetch_pc + STRIDE;
        end
        if (bus.mem_resp_valid) begin
          if (drop != '0) begin
            drop <= drop - CW'(1);
          end else begin
            resp_pc <= resp_pc + STRIDE;
          end
        end
      end
    end
  end

  no_orphan_resp: assert property (@(posedge clk) disable iff (rst)
    !(bus.mem_resp_valid && outstanding == '0));

  no_push_full: assert property (@(posedge clk) disable iff (rst)
    !(keep_resp_c && fifo_full && !pop_c));

  drop_bounded: assert property (@(posedge clk) disable iff (rst)
    drop <= outstanding);

  req_held: assert property (@(posedge clk) disable iff (rst)
    (req_valid_c && !bus.mem_req_ready) |=> (bus.redirect || (req_valid_c && $stable(fetch_pc))));

endmodule

// File: tb/tb_instr_prefetch.sv
// Directed-plus-random bench for instr_prefetch against a stream-level reference model.
// Model: expected fetch stream, in-flight request list with stale marking, and buffered entries.
module tb_instr_prefetch;

  localparam int          DEPTH  = 4;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic clk;
  logic rst;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  instr_prefetch_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  instr_prefetch #(
    .DEPTH    (DEPTH),
    .ADDR_W   (32),
    .DATA_W   (32),
    .RESET_PC (RST_PC)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int acc_cnt;
  int pop_cnt;
  logic [31:0] last_pop_addr;
  logic [31:0] salt;

  logic        s_valid;
  logic [31:0] s_addr;
  logic        s_ivalid;
  logic [31:0] s_iaddr;
  logic [31:0] s_instr;

  // Reference model state
  logic [31:0] m_pc;
  logic [31:0] fq_addr[$];
  logic [31:0] fq_data[$];
  logic [31:0] if_addr[$];
  logic [31:0] if_data[$];
  bit          if_live[$];
  int          if_cyc[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.mem_req_ready  = 1'b0;
    bus.mem_resp_valid = 1'b0;
    bus.mem_resp_data  = 32'h0;
    bus.instr_ready    = 1'b0;
    bus.redirect       = 1'b0;
    bus.redirect_addr  = 32'h0;
  endtask

  task automatic model_reset();
    m_pc = RST_PC;
    fq_addr.delete();
    fq_data.delete();
    if_addr.delete();
    if_data.delete();
    if_live.delete();
    if_cyc.delete();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req_valid"}, 32'(bus.mem_req_valid), 32'd0);
    chk({tag, "_req_addr"}, bus.mem_req_addr, RST_PC);
    chk({tag, "_instr_valid"}, 32'(bus.instr_valid), 32'd0);
    chk({tag, "_instr"}, bus.instr, 32'd0);
    chk({tag, "_instr_addr"}, bus.instr_addr, 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    rst = 1'b1;
    #1;
    chk_reset_outputs("rst");
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One clock: drive inputs at negedge, check outputs, then advance the model across the next edge.
  task automatic cycle(input bit rdy, input int resp_pct, input int irdy_pct,
                       input bit redir, input logic [31:0] raddr);
    bit resp;
    bit irdy;
    bit exp_v;
    bit acc;
    bit pop;
    @(negedge clk);
    resp = (if_addr.size() != 0) && (if_cyc[0] < cyc) && (int'($urandom_range(99)) < resp_pct);
    irdy = int'($urandom_range(99)) < irdy_pct;
    bus.mem_req_ready  = rdy;
    bus.mem_resp_valid = resp;
    bus.mem_resp_data  = resp ? if_data[0] : $urandom;
    bus.instr_ready    = irdy;
    bus.redirect       = redir;
    bus.redirect_addr  = redir ? raddr : $urandom;
    #1;
    s_valid  = bus.mem_req_valid;
    s_addr   = bus.mem_req_addr;
    s_ivalid = bus.instr_valid;
    s_iaddr  = bus.instr_addr;
    s_instr  = bus.instr;

    exp_v = !redir && ((if_addr.size() + fq_addr.size()) < DEPTH);
    chk("req_valid", 32'(s_valid), 32'(exp_v));
    if (exp_v) chk("req_addr", s_addr, m_pc);
    chk("instr_valid", 32'(s_ivalid), 32'(fq_addr.size() != 0));
    if (fq_addr.size() != 0) begin
      chk("instr_addr", s_iaddr, fq_addr[0]);
      chk("instr", s_instr, fq_data[0]);
    end

    acc = exp_v && rdy;
    pop = irdy && (fq_addr.size() != 0) && !redir;
    if (acc) begin
      if_addr.push_back(m_pc);
      if_data.push_back(m_pc ^ salt);
      if_live.push_back(1'b1);
      if_cyc.push_back(cyc);
      m_pc = m_pc + 32'd4;
      acc_cnt++;
    end
    if (pop) begin
      last_pop_addr = fq_addr[0];
      void'(fq_addr.pop_front());
      void'(fq_data.pop_front());
      pop_cnt++;
    end
    if (resp) begin
      if (if_live[0] && !redir) begin
        fq_addr.push_back(if_addr[0]);
        fq_data.push_back(if_data[0]);
      end
      void'(if_addr.pop_front());
      void'(if_data.pop_front());
      void'(if_live.pop_front());
      void'(if_cyc.pop_front());
    end
    if (redir) begin
      fq_addr.delete();
      fq_data.delete();
      foreach (if_live[i]) if_live[i] = 1'b0;
      m_pc = raddr & ~32'd3;
    end
    cyc++;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit          found;
    bit          rd;
    logic [31:0] ra;

    salt = 32'h0;
    acc_cnt = 0;
    pop_cnt = 0;
    last_pop_addr = 32'h0;
    idle_inputs();
    rst = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk_reset_outputs("por");
    model_reset();
    @(negedge clk);
    rst = 1'b0;

    // Streaming with a one-cycle memory returning data == addr
    acc_cnt = 0; pop_cnt = 0;
    repeat (12) cycle(1'b1, 100, 100, 1'b0, 32'h0);
    chk("t1_pops", 32'(pop_cnt), 32'd10);
    chk("t1_last_addr", last_pop_addr, 32'h24);

    // Core stalled: credit caps requests at the FIFO depth
    do_reset();
    salt = 32'h1111_0000; acc_cnt = 0;
    repeat (10) cycle(1'b1, 100, 0, 1'b0, 32'h0);
    chk("t2_accepts", 32'(acc_cnt), 32'd4);
    chk("t2_stalled", 32'(s_valid), 32'd0);
    cycle(1'b1, 100, 100, 1'b0, 32'h0);
    cycle(1'b0, 100, 0, 1'b0, 32'h0);
    chk("t2_resume_valid", 32'(s_valid), 32'd1);
    chk("t2_resume_addr", s_addr, 32'h10);

    // Redirect with two requests in flight, unaligned target
    do_reset();
    salt = 32'h2222_0000;
    cycle(1'b1, 0, 0, 1'b0, 32'h0);
    cycle(1'b1, 0, 0, 1'b0, 32'h0);
    cycle(1'b1, 0, 0, 1'b1, 32'h103);
    chk("t3_redir_valid", 32'(s_valid), 32'd0);
    cycle(1'b1, 100, 0, 1'b0, 32'h0);
    chk("t3_next_valid", 32'(s_valid), 32'd1);
    chk("t3_next_addr", s_addr, 32'h100);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      cycle(1'b1, 100, 0, 1'b0, 32'h0);
      found = s_ivalid;
    end
    chk("t3_found", 32'(found), 32'd1);
    chk("t3_first_addr", s_iaddr, 32'h100);
    chk("t3_first_instr", s_instr, 32'h100 ^ salt);

    // Response arriving in the redirect cycle with entries buffered and one more in flight
    do_reset();
    salt = 32'h3333_0000;
    repeat (6) cycle(1'b1, 0, 0, 1'b0, 32'h0);
    repeat (2) cycle(1'b0, 100, 0, 1'b0, 32'h0);
    cycle(1'b0, 100, 0, 1'b1, 32'h200);
    cycle(1'b0, 0, 0, 1'b0, 32'h0);
    chk("t4_flushed", 32'(s_ivalid), 32'd0);
    chk("t4_req_valid", 32'(s_valid), 32'd1);
    chk("t4_req_addr", s_addr, 32'h200);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      cycle(1'b1, 100, 0, 1'b0, 32'h0);
      found = s_ivalid;
    end
    chk("t4_found", 32'(found), 32'd1);
    chk("t4_first_addr", s_iaddr, 32'h200);

    // Full FIFO then continuous consumption: order preserved, no bubbles
    do_reset();
    salt = 32'h4444_0000;
    repeat (8) cycle(1'b1, 100, 0, 1'b0, 32'h0);
    chk("t5_full_stall", 32'(s_valid), 32'd0);
    pop_cnt = 0;
    repeat (16) cycle(1'b1, 100, 100, 1'b0, 32'h0);
    chk("t5_pops", 32'(pop_cnt), 32'd16);
    chk("t5_last_addr", last_pop_addr, 32'h3C);

    // Random traffic with occasional redirects, some near the address wrap
    do_reset();
    for (int i = 0; i < 600; i++) begin
      rd = int'($urandom_range(99)) < 4;
      ra = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15))) : $urandom;
      if ($urandom_range(49) == 0) salt = $urandom;
      cycle(bit'(int'($urandom_range(99)) < 70), 60, 60, rd, ra);
    end

    // Asynchronous reset mid-cycle with three requests in flight
    do_reset();
    salt = 32'h6666_0000;
    repeat (3) cycle(1'b1, 0, 0, 1'b0, 32'h0);
    @(posedge clk);
    #2;
    rst = 1'b1;
    idle_inputs();
    #1;
    chk_reset_outputs("midrst");
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      cycle(1'b1, 100, 0, 1'b0, 32'h0);
      found = s_ivalid;
    end
    chk("t6_found", 32'(found), 32'd1);
    chk("t6_first_addr", s_iaddr, RST_PC);
    chk("t6_first_instr", s_instr, RST_PC ^ salt);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
